// File: rtl/frame_loader.sv
// frame_loader: receives a UART byte stream, waits for a header byte, then
// converts each following byte to a signed fixed-point pixel through a
// 256-entry normalisation table and writes it to the IFMAP BRAM in CHW order.
// A frame is aborted if the line goes idle for TIMEOUT_CLKS clocks.
// Optional feature macro: FRAME_CHECKSUM_EN adds an 8-bit XOR trailer byte
// that is checked in a CHECK state before the frame is reported as loaded.
//
// Handshake: rx_dv is a one-cycle strobe qualifying rx_byte; there is no
// back-pressure. Each accepted pixel produces exactly one wr_en pulse on the
// following cycle. frame_loaded / frame_error are single-cycle pulses.
module frame_loader #(
  parameter int          DATA_WIDTH   = 16,
  parameter int          FRAC_BITS    = 7,
  parameter int          IMG_SIZE     = 28,
  parameter int          IN_CHANNELS  = 1,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CLKS = 1_000_000,
  localparam int         FRAME_SZ     = IN_CHANNELS * IMG_SIZE * IMG_SIZE,
  localparam int         AW           = $clog2(FRAME_SZ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  input  logic                  pipe_busy,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  loading,
  output logic                  frame_loaded,
  output logic                  frame_error,
  output logic [7:0]            err_count,
  output logic [1:0]            dbg_state
);

  // Pixel index must be able to hold FRAME_SZ itself ("all pixels received").
  localparam int IW = $clog2(FRAME_SZ + 1);
  localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_idx;
  logic [TW-1:0]         r_tmo;
  logic                  r_wr_en;
  logic [AW-1:0]         r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [7:0]            r_err_count;

  logic                  w_active;
  logic                  w_start;
  logic                  w_full;
  logic                  w_timeout;
  logic                  w_pix;
  logic                  w_err;

  // Normalisation table: byte k maps to round(k * 2^FRAC_BITS / 255), sign bit 0.
  logic [DATA_WIDTH-1:0] w_lut [256];
  for (genvar gk = 0; gk < 256; gk++) begin : g_lut
    localparam logic [31:0] LV = (gk * (2 ** FRAC_BITS) + 127) / 255;
    assign w_lut[gk] = {1'b0, LV[DATA_WIDTH-2:0]};
  end

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       w_ck_bad;
  logic       w_ck_ok;
  assign w_active  = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_ck_ok   = (r_state == S_CHECK) && rx_dv && !w_timeout && (rx_byte == r_csum);
  assign w_ck_bad  = (r_state == S_CHECK) && rx_dv && !w_timeout && (rx_byte != r_csum);
`else
  assign w_active  = (r_state == S_LOAD);
`endif

  assign w_start   = (r_state == S_IDLE) && rx_dv && (rx_byte == SYNC_BYTE) && !pipe_busy;
  assign w_full    = (r_idx == IW'(FRAME_SZ));
  assign w_timeout = w_active && (r_tmo == TW'(TIMEOUT_CLKS - 1));
  // In LOAD every byte, the header value included, is pixel data.
  assign w_pix     = (r_state == S_LOAD) && rx_dv && !w_full && !w_timeout;

`ifdef FRAME_CHECKSUM_EN
  assign w_err     = w_timeout || w_ck_bad;
`else
  assign w_err     = w_timeout;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; pipe_busy is only consulted when starting a frame.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_timeout) w_state_nxt = S_IDLE;
`ifdef FRAME_CHECKSUM_EN
        else if (w_full) w_state_nxt = S_CHECK;
`else
        else if (w_full) w_state_nxt = S_DONE;
`endif
      end
`ifdef FRAME_CHECKSUM_EN
      S_CHECK: begin
        if (w_timeout)     w_state_nxt = S_IDLE;
        else if (w_ck_ok)  w_state_nxt = S_DONE;
        else if (w_ck_bad) w_state_nxt = S_IDLE;
      end
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    loading      = w_active;
    frame_loaded = (r_state == S_DONE);
    frame_error  = w_err;
    dbg_state    = r_state;
  end

  // Pixel index and idle-line timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= '0;
      r_tmo <= '0;
    end else begin
      if (w_start)    r_idx <= '0;
      else if (w_pix) r_idx <= r_idx + 1'b1;
      if (!w_active || rx_dv) r_tmo <= '0;
      else                    r_tmo <= r_tmo + 1'b1;
    end
  end

  // Registered BRAM write port: one write per accepted pixel, one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_pix;
      if (w_pix) begin
        r_wr_addr <= r_idx[AW-1:0];
        r_wr_data <= w_lut[rx_byte];
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  // Running XOR of the pixel bytes of the current frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_csum <= '0;
    else if (w_start) r_csum <= '0;
    else if (w_pix)   r_csum <= r_csum ^ rx_byte;
  end
`endif

  // Saturating count of aborted frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_err_count <= '0;
    else if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_frame_loader.sv
// Testbench for frame_loader (28x28x1 frames, TIMEOUT_CLKS = 50).
// Expected pixel stream is built from the byte sequence sent, using the
// rounding rule round(k*128/255) and CHW address order.
module tb_frame_loader;

  localparam int         DW       = 16;
  localparam int         FRAC     = 7;
  localparam int         FRAME_SZ = 28 * 28;
  localparam int         AW       = 10;
  localparam int         TMO      = 50;
  localparam logic [7:0] SYNC     = 8'hA5;

  logic          clk;
  logic          reset_n;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          pipe_busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          loading;
  logic          frame_loaded;
  logic          frame_error;
  logic [7:0]    err_count;
  logic [1:0]    dbg_state;

  frame_loader #(
    .DATA_WIDTH(DW), .FRAC_BITS(FRAC), .IMG_SIZE(28), .IN_CHANNELS(1),
    .SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .pipe_busy(pipe_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .loading(loading), .frame_loaded(frame_loaded), .frame_error(frame_error),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int exp_err = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] got_addr_q[$];
  logic [DW-1:0] got_data_q[$];
  int n_loaded, n_error;
  int loaded_cyc, error_cyc, last_wr_cyc, last_dv_cyc;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      got_addr_q.push_back(wr_addr);
      got_data_q.push_back(wr_data);
      last_wr_cyc = cyc;
    end
    if (rx_dv) last_dv_cyc = cyc;
    if (frame_loaded) begin n_loaded++; loaded_cyc = cyc; end
    if (frame_error)  begin n_error++;  error_cyc  = cyc; end
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] lut_ref(input logic [7:0] k);
    int v;
    v = (int'(k) * (1 << FRAC) + 127) / 255;
    return DW'(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    exp_addr_q.delete(); exp_q.delete();
    got_addr_q.delete(); got_data_q.delete();
    n_loaded = 0; n_error = 0;
    loaded_cyc = -1; error_cyc = -1; last_wr_cyc = -1; last_dv_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_dv = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_byte = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  // Header + n_pix pixels (+ checksum trailer for full frames when enabled).
  // seq: pixel i = i mod 256, else random with pixel 5 forced to the header value.
  task automatic send_frame(input int n_pix, input bit seq, input int busy_at, input bit bad_ck);
    logic [7:0] b;
    logic [7:0] ck;
    ck = 8'h00;
    send_byte(SYNC);
    for (int i = 0; i < n_pix; i++) begin
      if (i == busy_at) pipe_busy = 1'b1;
      if (seq)         b = 8'(i);
      else if (i == 5) b = SYNC;
      else             b = 8'($urandom_range(0, 255));
      ck ^= b;
      exp_addr_q.push_back(AW'(i));
      exp_q.push_back(lut_ref(b));
      send_byte(b);
    end
`ifdef FRAME_CHECKSUM_EN
    if (n_pix == FRAME_SZ) send_byte(bad_ck ? (ck ^ 8'h01) : ck);
`else
    if (bad_ck) ck = 8'h00;
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; pipe_busy = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    vectors++; if (wr_addr !== '0) begin miscompares++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
    vectors++; if (wr_data !== '0) begin miscompares++; $display("FAIL reset_wr_data got %0d want 0", wr_data); end
    vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL reset_loading got %b want 0", loading); end
    vectors++; if (frame_loaded !== 1'b0) begin miscompares++; $display("FAIL reset_frame_loaded got %b want 0", frame_loaded); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_frame_error got %b want 0", frame_error); end
    vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    reset_n = 1'b1;
    exp_err = 0;
    repeat (3) @(negedge clk);
    vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL post_reset_loading got %b want 0", loading); end
  endtask

  task automatic test_full_frame();
    clear_mon();
    send_frame(FRAME_SZ, 1'b1, -1, 1'b0);
    repeat (6) @(posedge clk);
    vectors++; if (got_addr_q.size() != exp_addr_q.size()) begin miscompares++;
      $display("FAIL full_frame_count got %0d want %0d", got_addr_q.size(), exp_addr_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_addr_q.size(); i++) begin
      vectors++;
      if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_q[i]) begin miscompares++;
        $display("FAIL full_frame_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, got_addr_q[i], got_data_q[i], exp_addr_q[i], exp_q[i]); end
    end
    if (got_data_q.size() > 255) begin
      vectors++; if (got_data_q[255] !== 16'd128) begin miscompares++;
        $display("FAIL full_frame_lut255 got %0d want 128", got_data_q[255]); end
      vectors++; if (got_data_q[0] !== 16'd0) begin miscompares++;
        $display("FAIL full_frame_lut0 got %0d want 0", got_data_q[0]); end
    end
    vectors++; if (n_loaded != 1) begin miscompares++; $display("FAIL full_frame_loaded_pulses got %0d want 1", n_loaded); end
`ifdef FRAME_CHECKSUM_EN
    vectors++; if (loaded_cyc != last_dv_cyc + 1) begin miscompares++;
      $display("FAIL full_frame_loaded_time got %0d want %0d", loaded_cyc, last_dv_cyc + 1); end
`else
    vectors++; if (loaded_cyc != last_wr_cyc + 1) begin miscompares++;
      $display("FAIL full_frame_loaded_time got %0d want %0d", loaded_cyc, last_wr_cyc + 1); end
`endif
    vectors++; if (n_error != 0) begin miscompares++; $display("FAIL full_frame_errors got %0d want 0", n_error); end
    vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL full_frame_loading_end got %b want 0", loading); end
  endtask

  task automatic test_idle_drop();
    clear_mon();
    send_byte(8'h00);
    send_byte(8'h3C);
    repeat (3) @(posedge clk);
    vectors++; if (got_addr_q.size() != 0) begin miscompares++; $display("FAIL idle_drop_writes got %0d want 0", got_addr_q.size()); end
    vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL idle_drop_loading got %b want 0", loading); end
    send_frame(FRAME_SZ, 1'b0, -1, 1'b0);
    repeat (6) @(posedge clk);
    vectors++; if (got_addr_q.size() != exp_addr_q.size()) begin miscompares++;
      $display("FAIL idle_drop_count got %0d want %0d", got_addr_q.size(), exp_addr_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_addr_q.size(); i++) begin
      vectors++;
      if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_q[i]) begin miscompares++;
        $display("FAIL idle_drop_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, got_addr_q[i], got_data_q[i], exp_addr_q[i], exp_q[i]); end
    end
    vectors++; if (n_loaded != 1) begin miscompares++; $display("FAIL idle_drop_loaded got %0d want 1", n_loaded); end
  endtask

  task automatic test_pipe_busy();
    clear_mon();
    pipe_busy = 1'b1;
    send_byte(SYNC);
    send_byte(8'h10);
    repeat (3) @(negedge clk);
    vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL busy_refuse_loading got %b want 0", loading); end
    vectors++; if (got_addr_q.size() != 0) begin miscompares++; $display("FAIL busy_refuse_writes got %0d want 0", got_addr_q.size()); end
    pipe_busy = 1'b0;
    send_frame(FRAME_SZ, 1'b0, 200, 1'b0);
    repeat (6) @(posedge clk);
    pipe_busy = 1'b0;
    vectors++; if (got_addr_q.size() != exp_addr_q.size()) begin miscompares++;
      $display("FAIL busy_mid_count got %0d want %0d", got_addr_q.size(), exp_addr_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_addr_q.size(); i++) begin
      vectors++;
      if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_q[i]) begin miscompares++;
        $display("FAIL busy_mid_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, got_addr_q[i], got_data_q[i], exp_addr_q[i], exp_q[i]); end
    end
    vectors++; if (n_loaded != 1) begin miscompares++; $display("FAIL busy_mid_loaded got %0d want 1", n_loaded); end
  endtask

  task automatic test_timeout();
    clear_mon();
    send_frame(100, 1'b0, -1, 1'b0);
    repeat (TMO + 10) @(posedge clk);
    exp_err++;
    vectors++; if (got_addr_q.size() != 100) begin miscompares++; $display("FAIL timeout_writes got %0d want 100", got_addr_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_addr_q.size(); i++) begin
      vectors++;
      if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_q[i]) begin miscompares++;
        $display("FAIL timeout_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, got_addr_q[i], got_data_q[i], exp_addr_q[i], exp_q[i]); end
    end
    vectors++; if (n_error != 1) begin miscompares++; $display("FAIL timeout_pulses got %0d want 1", n_error); end
    vectors++; if (error_cyc - last_dv_cyc != TMO) begin miscompares++;
      $display("FAIL timeout_latency got %0d want %0d", error_cyc - last_dv_cyc, TMO); end
    vectors++; if (err_count !== 8'(exp_err)) begin miscompares++; $display("FAIL timeout_err_count got %0d want %0d", err_count, exp_err); end
    vectors++; if (n_loaded != 0) begin miscompares++; $display("FAIL timeout_loaded got %0d want 0", n_loaded); end
    vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL timeout_loading got %b want 0", loading); end
    clear_mon();
    send_frame(FRAME_SZ, 1'b0, -1, 1'b0);
    repeat (6) @(posedge clk);
    vectors++; if (got_addr_q.size() != exp_addr_q.size()) begin miscompares++;
      $display("FAIL timeout_restart_count got %0d want %0d", got_addr_q.size(), exp_addr_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_addr_q.size(); i++) begin
      vectors++;
      if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_q[i]) begin miscompares++;
        $display("FAIL timeout_restart_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, got_addr_q[i], got_data_q[i], exp_addr_q[i], exp_q[i]); end
    end
    vectors++; if (n_loaded != 1) begin miscompares++; $display("FAIL timeout_restart_loaded got %0d want 1", n_loaded); end
  endtask

`ifdef FRAME_CHECKSUM_EN
  task automatic test_checksum();
    clear_mon();
    send_frame(FRAME_SZ, 1'b0, -1, 1'b0);
    repeat (6) @(posedge clk);
    vectors++; if (n_loaded != 1) begin miscompares++; $display("FAIL ck_good_loaded got %0d want 1", n_loaded); end
    vectors++; if (n_error != 0) begin miscompares++; $display("FAIL ck_good_error got %0d want 0", n_error); end
    clear_mon();
    send_frame(FRAME_SZ, 1'b0, -1, 1'b1);
    repeat (6) @(posedge clk);
    exp_err++;
    vectors++; if (got_addr_q.size() != FRAME_SZ) begin miscompares++; $display("FAIL ck_bad_writes got %0d want %0d", got_addr_q.size(), FRAME_SZ); end
    vectors++; if (n_loaded != 0) begin miscompares++; $display("FAIL ck_bad_loaded got %0d want 0", n_loaded); end
    vectors++; if (n_error != 1) begin miscompares++; $display("FAIL ck_bad_error got %0d want 1", n_error); end
    vectors++; if (err_count !== 8'(exp_err)) begin miscompares++; $display("FAIL ck_bad_err_count got %0d want %0d", err_count, exp_err); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int errs_before;
    clear_mon();
    send_frame(300, 1'b0, -1, 1'b0);
    @(posedge clk); #2;
    vectors++; if (loading !== 1'b1) begin miscompares++; $display("FAIL rstmid_loading_before got %b want 1", loading); end
    errs_before = n_error;
    #1 reset_n = 1'b0;
    exp_err = 0;
    #1;
    vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL rstmid_loading got %b want 0", loading); end
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL rstmid_wr_en got %b want 0", wr_en); end
    vectors++; if (wr_addr !== '0) begin miscompares++; $display("FAIL rstmid_wr_addr got %0d want 0", wr_addr); end
    vectors++; if (wr_data !== '0) begin miscompares++; $display("FAIL rstmid_wr_data got %0d want 0", wr_data); end
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    vectors++; if (n_error != errs_before) begin miscompares++; $display("FAIL rstmid_error_pulse got %0d want %0d", n_error, errs_before); end
    vectors++; if (err_count !== 8'(exp_err)) begin miscompares++; $display("FAIL rstmid_err_count got %0d want %0d", err_count, exp_err); end
    clear_mon();
    send_byte(8'h42);
    repeat (3) @(posedge clk);
    vectors++; if (got_addr_q.size() != 0) begin miscompares++; $display("FAIL rstmid_stray_writes got %0d want 0", got_addr_q.size()); end
    send_frame(FRAME_SZ, 1'b1, -1, 1'b0);
    repeat (6) @(posedge clk);
    vectors++; if (got_addr_q.size() != exp_addr_q.size()) begin miscompares++;
      $display("FAIL rstmid_count got %0d want %0d", got_addr_q.size(), exp_addr_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_addr_q.size(); i++) begin
      vectors++;
      if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_q[i]) begin miscompares++;
        $display("FAIL rstmid_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, got_addr_q[i], got_data_q[i], exp_addr_q[i], exp_q[i]); end
    end
    vectors++; if (n_loaded != 1) begin miscompares++; $display("FAIL rstmid_loaded got %0d want 1", n_loaded); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_frame();
    test_idle_drop();
    test_pipe_busy();
    test_timeout();
`ifdef FRAME_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the stored fixed-point pixel.
REQ-002 Parameter FRAC_BITS, default 7: fractional bits of the stored pixel.
REQ-003 Parameter IMG_SIZE, default 28: image height and width in pixels.
REQ-004 Parameter IN_CHANNELS, default 1: channels per frame; FRAME_SZ = IN_CHANNELS*IMG_SIZE*IMG_SIZE; AW = $clog2(FRAME_SZ).
REQ-005 Parameter SYNC_BYTE, default 8'hA5: frame header byte.
REQ-006 Parameter TIMEOUT_CLKS, default 1_000_000: maximum idle clocks between bytes inside a frame.
REQ-007 clk  in  1  sole clock; all state changes on the rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 rx_dv  in  1  one-cycle strobe, rx_byte valid.
REQ-010 rx_byte  in  8  received UART byte.
REQ-011 pipe_busy  in  1  high while the downstream pipeline is processing; new frames are refused.
REQ-012 wr_en  out  1  IFMAP BRAM write strobe (enable and write-enable).
REQ-013 wr_addr  out  AW  IFMAP write address.
REQ-014 wr_data  out  DATA_WIDTH  signed fixed-point pixel.
REQ-015 loading  out  1  high from header acceptance until frame end or abort.
REQ-016 frame_loaded  out  1  one-cycle pulse, frame complete and valid.
REQ-017 frame_error  out  1  one-cycle pulse, frame aborted.
REQ-018 err_count  out  8  saturating count of frame_error pulses.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, CHECK and DONE.
REQ-020 IDLE: rx_dv with rx_byte==SYNC_BYTE and pipe_busy==0 -> LOAD with pixel index 0; all other bytes are dropped silently.
REQ-021 LOAD: each rx_dv SHALL, one cycle later, assert wr_en for one cycle with wr_addr=pixel index and wr_data=LUT[rx_byte], then increment the index.
REQ-022 Pixel order is CHW; the address equals (ch*IMG_SIZE+row)*IMG_SIZE+col and increases monotonically from 0 to FRAME_SZ-1.
REQ-023 LUT[k] = (k*2^FRAC_BITS+127)/255 in integer arithmetic, truncated to DATA_WIDTH, zero sign bit (k=0 -> 0, k=255 -> 2^FRAC_BITS).
REQ-024 In LOAD, a byte equal to SYNC_BYTE is pixel data and does not restart the frame.
REQ-025 After the write for index FRAME_SZ-1, the FSM SHALL go to CHECK if FRAME_CHECKSUM_EN is defined, otherwise to DONE.
REQ-026 DONE lasts one cycle; frame_loaded=1 in that cycle, one cycle after the final wr_en; then -> IDLE.
REQ-027 pipe_busy changing during LOAD or CHECK has no effect on the frame in progress.
REQ-028 Timeout counter: cleared on entry to LOAD and on every rx_dv in LOAD or CHECK; when it reaches TIMEOUT_CLKS-1 -> frame_error pulse, -> IDLE, no further writes.
REQ-029 frame_error increments err_count, which holds at 255.
REQ-030 loading = (state==LOAD or state==CHECK).
REQ-031 wr_en is never asserted outside LOAD or the final-pixel write cycle.

Reset
REQ-032 While reset_n=0 the block SHALL be in IDLE with pixel index, timeout counter, checksum register, err_count, wr_en, wr_addr, wr_data, loading, frame_loaded and frame_error all 0.
REQ-033 Reset asserted mid-frame SHALL discard the frame without asserting frame_error; after release, only a new SYNC_BYTE starts a frame.

Configuration
REQ-034 Macro FRAME_CHECKSUM_EN defined: the block keeps an 8-bit XOR of all pixel bytes in the frame; in CHECK, the next rx_dv byte is compared with it; match -> DONE, mismatch -> frame_error and IDLE; the timeout also applies in CHECK.
REQ-035 Macro FRAME_CHECKSUM_EN undefined: there is no CHECK state and no checksum logic, and the frame ends after pixel FRAME_SZ-1.

Verification
REQ-036 Reset, then A5 followed by 784 bytes k mod 256 (IMG_SIZE 28, 1 channel) -> 784 writes at addresses 0..783, wr_data(255)=128, frame_loaded pulses once one cycle after the last wr_en.
REQ-037 Bytes 00, 3C, then A5 and a full frame, sent in IDLE -> no writes for 00 or 3C; the frame loads normally.
REQ-038 pipe_busy=1 while A5 is received in IDLE -> byte dropped, loading stays 0; pipe_busy then raised mid-frame -> frame completes.
REQ-039 Frame stopped after 100 pixels, TIMEOUT_CLKS=50 -> frame_error exactly 50 clocks after the last rx_dv, err_count=1, next A5 restarts at address 0.
REQ-040 FRAME_CHECKSUM_EN defined: correct XOR trailer -> frame_loaded; trailer XOR^8'h01 -> frame_error, no frame_loaded.
REQ-041 reset_n pulsed low after pixel 300 -> outputs 0 immediately (asynchronously), err_count unchanged at 0, the next full frame loads from address 0.
